// File: rtl/audio_sram_pkg.sv
// Shared types and constants for the audio record/playback sequencer.
// state_o encodings are the ST_* constants below.
package audio_sram_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RECORD = 2'd1;
  localparam logic [1:0] ST_PLAY   = 2'd2;

endpackage

// File: rtl/sram_access_seq.sv
// Single SRAM access strobe generator: start at t -> strobe t+1..t+ACC_CYCLES, done at t+ACC_CYCLES+1.
// Starts are ignored while busy; the caller decides what an ignored start means.
module sram_access_seq #(
  parameter int ACC_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_write,
  output logic rd,
  output logic wr,
  output logic busy,
  output logic last,
  output logic done,
  output logic op_write
);

  localparam int CNT_W = $clog2(ACC_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  assign busy = (cnt != '0);
  assign last = (cnt == CNT_W'(1));
  assign rd   = busy & ~op_write;
  assign wr   = busy & op_write;

  // op_write holds after the access so the done cycle still knows what finished
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_write <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= last;
      if (start && !busy) begin
        cnt      <= CNT_W'(ACC_CYCLES);
        op_write <= is_write;
      end else if (busy) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/audio_sram_ctrl.sv
// Record/playback sequencer feeding the SRAM port block; one access per sample tick, dac_valid at tick+ACC_CYCLES+1.
// Optional PLAY_LOOP_EN: playback wraps to address 0 at the recorded end instead of stopping.
module audio_sram_ctrl
  import audio_sram_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                DATA_W     = DATA_W_DEF,
  parameter int                ACC_CYCLES = 2,
  parameter logic [ADDR_W-1:0] MAX_ADDR   = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_record,
  input  logic              btn_play,
  input  logic              btn_stop,
  input  logic              smp_tick,
  input  logic [DATA_W-1:0] adc_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_read,
  output logic              sram_write,
  output logic              sram_record,
  output logic              sram_play,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic [1:0]        state_o,
  output logic              full,
  output logic              overrun
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] end_addr;
  logic              rec_valid;
  logic              pend_stop;

  logic seq_rd, seq_wr, seq_busy, seq_last, seq_done, seq_op_wr;
  logic seq_start;
  logic stop_now;

  // A stop in the same cycle as a tick wins; the tick is not turned into an access.
  assign seq_start = (state != ST_IDLE) && !seq_busy && !btn_stop && smp_tick;
  assign stop_now  = btn_stop | pend_stop;

  sram_access_seq #(
    .ACC_CYCLES (ACC_CYCLES)
  ) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (seq_start),
    .is_write (state == ST_RECORD),
    .rd       (seq_rd),
    .wr       (seq_wr),
    .busy     (seq_busy),
    .last     (seq_last),
    .done     (seq_done),
    .op_write (seq_op_wr)
  );

  assign sram_addr   = addr;
  assign sram_read   = seq_rd;
  assign sram_write  = seq_wr;
  assign sram_record = (state == ST_RECORD);
  assign sram_play   = (state == ST_PLAY);
  assign state_o     = state;
  assign dac_valid   = seq_done & ~seq_op_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr       <= '0;
      end_addr   <= '0;
      rec_valid  <= 1'b0;
      pend_stop  <= 1'b0;
      full       <= 1'b0;
      overrun    <= 1'b0;
      sram_wdata <= '0;
      dac_data   <= '0;
    end else begin
      if (smp_tick && seq_busy) begin
        overrun <= 1'b1;
      end

      if (seq_last) begin
        // Final strobe cycle: retire the access, then apply any stop seen during it.
        pend_stop <= 1'b0;
        if (state == ST_RECORD) begin
          end_addr  <= addr;
          rec_valid <= 1'b1;
          if (addr == MAX_ADDR) begin
            full  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            addr <= addr + ADDR_W'(1);
          end
        end else if (state == ST_PLAY) begin
          dac_data <= sram_rdata;
          if (addr == end_addr) begin
`ifdef PLAY_LOOP_EN
            addr <= '0;
`else
            state <= ST_IDLE;
`endif
          end else begin
            addr <= addr + ADDR_W'(1);
          end
        end
        if (stop_now) begin
          state <= ST_IDLE;
        end
      end else if (seq_busy) begin
        if (btn_stop) begin
          pend_stop <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (!btn_stop) begin
              if (btn_record) begin
                state   <= ST_RECORD;
                addr    <= '0;
                full    <= 1'b0;
                overrun <= 1'b0;
              end else if (btn_play && rec_valid) begin
                state <= ST_PLAY;
                addr  <= '0;
              end
            end
          end
          ST_RECORD, ST_PLAY: begin
            if (btn_stop) begin
              state <= ST_IDLE;
            end else if (smp_tick && state == ST_RECORD) begin
              sram_wdata <= adc_data;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_sram_ctrl.sv
// Bench for audio_sram_ctrl: directed record/play scenarios plus random traffic against a cycle-indexed model.
// Honours PLAY_LOOP_EN the same way as the design.
module tb_audio_sram_ctrl;
  import audio_sram_pkg::*;

  localparam int AW   = 18;
  localparam int DW   = 16;
  localparam int ACC  = 2;
  localparam int MAXA = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_record = 1'b0, btn_play = 1'b0, btn_stop = 1'b0, smp_tick = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic [AW-1:0] sram_addr;
  logic          sram_read, sram_write, sram_record, sram_play;
  logic [DW-1:0] sram_wdata, sram_rdata, dac_data;
  logic          dac_valid, full, overrun;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  audio_sram_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(ACC), .MAX_ADDR(18'd7)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_record(btn_record), .btn_play(btn_play),
    .btn_stop(btn_stop), .smp_tick(smp_tick), .adc_data(adc_data),
    .sram_addr(sram_addr), .sram_read(sram_read), .sram_write(sram_write),
    .sram_record(sram_record), .sram_play(sram_play), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .dac_data(dac_data), .dac_valid(dac_valid),
    .state_o(state_o), .full(full), .overrun(overrun)
  );

  // Behavioural SRAM behind the port block
  logic [DW-1:0] sram_mem [0:MAXA];
  assign sram_rdata = sram_mem[sram_addr[2:0]];
  always @(posedge clk) if (sram_write) sram_mem[sram_addr[2:0]] <= sram_wdata;

  int n_pass, n_checks;

  // Model: state 0 idle / 1 record / 2 play; an access accepted in cycle m_acc_t strobes cycles m_acc_t+1..m_acc_t+ACC
  int            cyc, m_st, m_addr, m_end, m_acc_t;
  bit            m_recv, m_full, m_ovr, m_pend, m_acc_wr, m_dacv;
  logic [DW-1:0] m_wdata, m_dac;
  logic [DW-1:0] ref_mem [0:MAXA];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    cyc = 0; m_st = 0; m_addr = 0; m_end = 0; m_acc_t = -1;
    m_recv = 0; m_full = 0; m_ovr = 0; m_pend = 0; m_acc_wr = 0; m_dacv = 0;
    m_wdata = '0; m_dac = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(sram_addr), 0);
    chk({tag, "_read"}, 32'(sram_read), 0);
    chk({tag, "_write"}, 32'(sram_write), 0);
    chk({tag, "_record"}, 32'(sram_record), 0);
    chk({tag, "_play"}, 32'(sram_play), 0);
    chk({tag, "_wdata"}, 32'(sram_wdata), 0);
    chk({tag, "_dac"}, 32'(dac_data), 0);
    chk({tag, "_dacv"}, 32'(dac_valid), 0);
    chk({tag, "_state"}, 32'(state_o), 0);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_ovr"}, 32'(overrun), 0);
  endtask

  task automatic compare_outputs();
    bit in_win;
    in_win = (m_acc_t >= 0) && (cyc >= m_acc_t + 1) && (cyc <= m_acc_t + ACC);
    chk("sram_write", 32'(sram_write), 32'(in_win && m_acc_wr));
    chk("sram_read", 32'(sram_read), 32'(in_win && !m_acc_wr));
    chk("sram_addr", 32'(sram_addr), 32'(m_addr));
    chk("sram_record", 32'(sram_record), 32'(m_st == 1));
    chk("sram_play", 32'(sram_play), 32'(m_st == 2));
    chk("sram_wdata", 32'(sram_wdata), 32'(m_wdata));
    chk("dac_data", 32'(dac_data), 32'(m_dac));
    chk("dac_valid", 32'(dac_valid), 32'(m_dacv));
    chk("state_o", 32'(state_o), 32'(m_st));
    chk("full", 32'(full), 32'(m_full));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic model_step();
    bit in_flight, ending, stop;
    in_flight = (m_acc_t >= 0) && (cyc >= m_acc_t + 1) && (cyc <= m_acc_t + ACC);
    ending    = in_flight && (cyc == m_acc_t + ACC);
    m_dacv = 0;
    if (in_flight && smp_tick) m_ovr = 1;
    if (ending) begin
      stop = m_pend || btn_stop;
      m_pend = 0;
      m_acc_t = -1;
      if (m_st == 1) begin
        m_end = m_addr; m_recv = 1;
        if (m_addr == MAXA) begin m_full = 1; m_st = 0; end
        else m_addr++;
      end else begin
        m_dac = ref_mem[m_addr]; m_dacv = 1;
        if (m_addr == m_end) begin
`ifdef PLAY_LOOP_EN
          m_addr = 0;
`else
          m_st = 0;
`endif
        end else m_addr++;
      end
      if (stop) m_st = 0;
    end else if (in_flight) begin
      if (btn_stop) m_pend = 1;
    end else if (m_st == 0) begin
      if (btn_stop) begin
      end else if (btn_record) begin
        m_st = 1; m_addr = 0; m_full = 0; m_ovr = 0;
      end else if (btn_play && m_recv) begin
        m_st = 2; m_addr = 0;
      end
    end else if (btn_stop) begin
      m_st = 0;
    end else if (smp_tick) begin
      m_acc_t = cyc;
      m_acc_wr = (m_st == 1);
      if (m_st == 1) begin
        m_wdata = adc_data;
        ref_mem[m_addr] = adc_data;
      end
    end
  endtask

  // One clock cycle: check the outputs of this cycle, drive its inputs, advance the model.
  task automatic do_cycle(input bit rec, input bit ply, input bit stp, input bit tk, input logic [DW-1:0] adc);
    @(negedge clk);
    compare_outputs();
    btn_record = rec; btn_play = ply; btn_stop = stp; smp_tick = tk; adc_data = adc;
    model_step();
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(0, 0, 0, 0, '0);
  endtask

  initial begin
    logic [DW-1:0] val;
    n_pass = 0; n_checks = 0;
    for (int i = 0; i <= MAXA; i++) ref_mem[i] = '0;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    model_reset();

    // Reset during an active write
    do_cycle(1, 0, 0, 0, '0);
    do_cycle(0, 0, 0, 1, 16'hABCD);
    do_cycle(0, 0, 0, 0, '0);
    chk("t1_write_before_reset", 32'(sram_write), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t1_mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_cycle(0, 1, 0, 0, '0);
    idle(1);
    chk("t1_play_ignored", 32'(state_o), 32'(ST_IDLE));

    // Record four samples
    do_cycle(1, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      val = 16'(32'h1111 * (i + 1));
      do_cycle(0, 0, 0, 1, val);
      idle(1);
      chk("t2_write_addr", 32'(sram_addr), 32'(i));
      chk("t2_write_data", 32'(sram_wdata), 32'(val));
      idle(1);
      chk("t2_write_2nd_cycle", 32'(sram_write), 1);
      idle(1);
      chk("t2_write_released", 32'(sram_write), 0);
    end
    do_cycle(0, 0, 1, 0, '0);
    idle(1);
    chk("t2_stopped", 32'(state_o), 32'(ST_IDLE));
    for (int i = 0; i < 4; i++) chk("t2_sram_content", 32'(sram_mem[i]), 32'(16'(32'h1111 * (i + 1))));

    // Play back the four samples
    do_cycle(0, 1, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      do_cycle(0, 0, 0, 1, '0);
      idle(3);
      chk("t3_dac_valid", 32'(dac_valid), 1);
      chk("t3_dac_data", 32'(dac_data), 32'(16'(32'h1111 * (i + 1))));
    end
`ifdef PLAY_LOOP_EN
    chk("t4_still_playing", 32'(state_o), 32'(ST_PLAY));
    do_cycle(0, 0, 0, 1, '0);
    idle(3);
    chk("t4_wrap_dac", 32'(dac_data), 32'h1111);
    do_cycle(0, 0, 1, 0, '0);
    idle(1);
    chk("t4_stopped", 32'(state_o), 32'(ST_IDLE));
`else
    chk("t3_idle_at_end", 32'(state_o), 32'(ST_IDLE));
`endif

    // Overrun and command priority
    do_cycle(1, 0, 0, 0, '0);
    do_cycle(0, 0, 0, 1, 16'h5555);
    do_cycle(0, 0, 0, 1, 16'h6666);
    idle(3);
    chk("t6_overrun", 32'(overrun), 1);
    chk("t6_first_written", 32'(sram_mem[0]), 32'h5555);
    chk("t6_second_dropped", 32'(sram_mem[1]), 32'h2222);
    do_cycle(0, 0, 1, 0, '0);
    do_cycle(1, 0, 1, 0, '0);
    idle(1);
    chk("t6_stop_beats_record", 32'(state_o), 32'(ST_IDLE));
    chk("t6_overrun_kept", 32'(overrun), 1);

    // Fill memory to MAX_ADDR
    do_cycle(1, 0, 0, 0, '0);
    for (int i = 0; i < 9; i++) begin
      do_cycle(0, 0, 0, 1, 16'(32'h7000 + i));
      idle(2);
    end
    idle(2);
    chk("t5_full", 32'(full), 1);
    chk("t5_idle", 32'(state_o), 32'(ST_IDLE));
    chk("t5_last_word", 32'(sram_mem[7]), 32'h7007);
    chk("t5_first_word", 32'(sram_mem[0]), 32'h7000);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      do_cycle($urandom_range(39) == 0, $urandom_range(24) == 0, $urandom_range(59) == 0,
               $urandom_range(2) == 0, 16'($urandom));
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
